// File: rtl/mod_fixed_div.sv
// mod_fixed_div: sequential unsigned fixed-point divider, out = (a << INPUT_POINT) / b,
// restoring shift-subtract with one quotient bit per clock.
module mod_fixed_div #(
  parameter int INPUT_WIDTH = 32,
  parameter int INPUT_POINT = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [INPUT_WIDTH-1:0] i_a,
  input  logic [INPUT_WIDTH-1:0] i_b,
  input  logic                   i_trigger,
  output logic [INPUT_WIDTH-1:0] o_out,
  output logic                   o_ready,
  output logic                   o_overflow,
  output logic                   o_div_zero
);
  localparam int W  = INPUT_WIDTH;
  localparam int N  = INPUT_WIDTH + INPUT_POINT;
  localparam int CW = $clog2(N);
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
  logic [1:0]    state_q, state_d;
  logic [N-1:0]  dvd_q, dvd_d, quo_q, quo_d, quo_nx;
  logic [W:0]    rem_q, rem_d;
  logic [W+1:0]  rem_sh;
  logic [W-1:0]  div_q, div_d, out_q, out_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d, dz_q, dz_d, ge;
  assign rem_sh = {rem_q, dvd_q[N-1]};
  assign ge     = rem_sh >= {2'b0, div_q};
  assign quo_nx = {quo_q[N-2:0], ge};
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    div_d   = div_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;
    if (state_q != BUSY) begin
      if (i_trigger) begin
        dvd_d   = {i_a, {INPUT_POINT{1'b0}}};
        div_d   = i_b;
        rem_d   = '0;
        quo_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
        dz_d    = 1'b0;
        state_d = BUSY;
      end
    end else if (div_q == '0) begin
      out_d   = '1;
      dz_d    = 1'b1;
      state_d = DONE;
    end else begin
      rem_d = (W+1)'(ge ? rem_sh - {2'b0, div_q} : rem_sh);
      dvd_d = dvd_q << 1;
      quo_d = quo_nx;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(N-1)) begin
        // quotient wider than the output format saturates
        ovf_d   = |quo_nx[N-1:W];
        out_d   = (|quo_nx[N-1:W]) ? '1 : quo_nx[W-1:0];
        state_d = DONE;
      end
    end
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end
  assign o_out      = out_q;
  assign o_ready    = state_q != BUSY;
  assign o_overflow = ovf_q;
  assign o_div_zero = dz_q;
endmodule
